// File: rtl/alu_writeback_stage_if.sv
// Result bus from the ALU into the writeback stage: the payload plus the
// valid/ready handshake that carries it.
interface alu_writeback_stage_if #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 7,
   parameter int ADDR_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [FLAG_W-1:0] in_flags;
   logic [ADDR_W-1:0] in_dest;
   logic              in_we_reg;
   logic              in_we_flags;

   modport master (
      output in_valid,
      output in_result,
      output in_flags,
      output in_dest,
      output in_we_reg,
      output in_we_flags,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_result,
      input  in_flags,
      input  in_dest,
      input  in_we_reg,
      input  in_we_flags,
      output in_ready
   );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback: one pending slot, commit into the register file and flag
// register, and forwarded read ports A/B feeding the next ALU operation.
module alu_writeback_stage #(
   parameter int DATA_W    = 8,
   parameter int FLAG_W    = 7,
   parameter int REG_COUNT = 8,
   parameter int ADDR_W    = 3,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_writeback_stage_if.slave  in_bus,
   input  logic                  hold,
   input  logic [1:0]            flag_ctrl,
   input  logic [ADDR_W-1:0]     rd_addr_a,
   output logic [DATA_W-1:0]     rd_data_a,
   input  logic [ADDR_W-1:0]     rd_addr_b,
   output logic [DATA_W-1:0]     rd_data_b,
   output logic [FLAG_W-1:0]     flags_q,
   output logic                  pending,
   output logic [CNT_W-1:0]      retired_count
);

   localparam int                I_BIT      = 4;
   localparam logic [FLAG_W-1:0] I_MASK     = FLAG_W'(1) << I_BIT;
   localparam logic [FLAG_W-1:0] IDLE_FLAGS = FLAG_W'(7'b0001001);

   logic              s1_valid_q,    s1_valid_d;
   logic [DATA_W-1:0] s1_result_q,   s1_result_d;
   logic [FLAG_W-1:0] s1_flags_q,    s1_flags_d;
   logic [ADDR_W-1:0] s1_dest_q,     s1_dest_d;
   logic              s1_we_reg_q,   s1_we_reg_d;
   logic              s1_we_flags_q, s1_we_flags_d;
   logic [DATA_W-1:0] reg_q [REG_COUNT];
   logic [DATA_W-1:0] reg_d [REG_COUNT];
   logic [FLAG_W-1:0] flags_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic commit;
   logic ready;
   logic accept;

   always_comb begin
      commit = s1_valid_q & ~hold;
      ready  = ~s1_valid_q | commit;
      accept = in_bus.in_valid & ready;
   end

   assign in_bus.in_ready = ready;

   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_result_d   = s1_result_q;
      s1_flags_d    = s1_flags_q;
      s1_dest_d     = s1_dest_q;
      s1_we_reg_d   = s1_we_reg_q;
      s1_we_flags_d = s1_we_flags_q;
      reg_d         = reg_q;
      flags_d       = flags_q;
      retired_d     = retired_q;

      // The slot drains on commit and may refill on the same edge, so a
      // steady stream runs without bubbles.
      if (accept) begin
         s1_valid_d    = 1'b1;
         s1_result_d   = in_bus.in_result;
         s1_flags_d    = in_bus.in_flags;
         s1_dest_d     = in_bus.in_dest;
         s1_we_reg_d   = in_bus.in_we_reg;
         s1_we_flags_d = in_bus.in_we_flags;
      end else if (commit) begin
         s1_valid_d = 1'b0;
      end

      if (commit) begin
         if (s1_we_reg_q) begin
            reg_d[s1_dest_q] = s1_result_q;
         end
         // The interrupt-enable bit belongs to flag_ctrl, never to the ALU.
         if (s1_we_flags_q) begin
            flags_d = (s1_flags_q & ~I_MASK) | (flags_q & I_MASK);
         end
         retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (flag_ctrl)
         2'b01:   flags_d[I_BIT] = 1'b1;
         2'b10:   flags_d[I_BIT] = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_result_q   <= '0;
         s1_flags_q    <= '0;
         s1_dest_q     <= '0;
         s1_we_reg_q   <= 1'b0;
         s1_we_flags_q <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) begin
            reg_q[i] <= '0;
         end
         flags_q       <= IDLE_FLAGS;
         retired_q     <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_result_q   <= s1_result_d;
         s1_flags_q    <= s1_flags_d;
         s1_dest_q     <= s1_dest_d;
         s1_we_reg_q   <= s1_we_reg_d;
         s1_we_flags_q <= s1_we_flags_d;
         reg_q         <= reg_d;
         flags_q       <= flags_d;
         retired_q     <= retired_d;
      end
   end

   // A pending write is visible to the next ALU op even while held.
   always_comb begin
      rd_data_a = reg_q[rd_addr_a];
      rd_data_b = reg_q[rd_addr_b];
      if (s1_valid_q && s1_we_reg_q && (s1_dest_q == rd_addr_a)) begin
         rd_data_a = s1_result_q;
      end
      if (s1_valid_q && s1_we_reg_q && (s1_dest_q == rd_addr_b)) begin
         rd_data_b = s1_result_q;
      end
   end

   assign pending       = s1_valid_q;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus random
// traffic, checked against a queue-based scoreboard of accepted ops.
module tb_alu_writeback_stage;

   localparam int DATA_W = 8;
   localparam int FLAG_W = 7;
   localparam int REG_COUNT = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W = 16;

   typedef struct {
      logic [DATA_W-1:0] result;
      logic [FLAG_W-1:0] flags;
      logic [ADDR_W-1:0] dest;
      logic              we_reg;
      logic              we_flags;
   } op_t;

   logic              clk;
   logic              rst_n;
   logic              hold;
   logic [1:0]        flag_ctrl;
   logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic [FLAG_W-1:0] flags_q;
   logic              pending;
   logic [CNT_W-1:0]  retired_count;

   int n_checks = 0;
   int n_fail = 0;

   alu_writeback_stage_if #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .ADDR_W(ADDR_W)) bus ();

   alu_writeback_stage #(
      .DATA_W(DATA_W), .FLAG_W(FLAG_W), .REG_COUNT(REG_COUNT),
      .ADDR_W(ADDR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_bus(bus.slave),
      .hold(hold),
      .flag_ctrl(flag_ctrl),
      .rd_addr_a(rd_addr_a),
      .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b),
      .rd_data_b(rd_data_b),
      .flags_q(flags_q),
      .pending(pending),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Scoreboard: accepted ops wait in sb_q until the model retires them.
   op_t               sb_q[$];
   op_t               m_op;
   logic [DATA_W-1:0] m_reg [REG_COUNT];
   logic [FLAG_W-1:0] m_flags;
   logic [CNT_W-1:0]  m_cnt;
   bit                m_take;

   always @(posedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         for (int i = 0; i < REG_COUNT; i++) m_reg[i] = '0;
         m_flags = 7'h09;
         m_cnt = '0;
      end else begin
         m_take = (sb_q.size() == 0) || !hold;
         if (sb_q.size() != 0 && !hold) begin
            m_op = sb_q.pop_front();
            if (m_op.we_reg) m_reg[m_op.dest] = m_op.result;
            if (m_op.we_flags) m_flags = {m_op.flags[6:5], m_flags[4], m_op.flags[3:0]};
            m_cnt = m_cnt + 1'b1;
         end
         if (flag_ctrl == 2'b01) m_flags[4] = 1'b1;
         else if (flag_ctrl == 2'b10) m_flags[4] = 1'b0;
         if (bus.in_valid && m_take) begin
            m_op.result = bus.in_result;
            m_op.flags = bus.in_flags;
            m_op.dest = bus.in_dest;
            m_op.we_reg = bus.in_we_reg;
            m_op.we_flags = bus.in_we_flags;
            sb_q.push_back(m_op);
         end
      end
   end

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (sb_q.size() != 0 && sb_q[0].we_reg && sb_q[0].dest == a) return sb_q[0].result;
      return m_reg[a];
   endfunction

   function automatic logic exp_ready();
      return (sb_q.size() == 0) || !hold;
   endfunction

   task automatic drive_op(input logic [DATA_W-1:0] r, input logic [FLAG_W-1:0] f,
                           input logic [ADDR_W-1:0] d, input logic wr, input logic wf);
      bus.in_valid = 1'b1;
      bus.in_result = r;
      bus.in_flags = f;
      bus.in_dest = d;
      bus.in_we_reg = wr;
      bus.in_we_flags = wf;
   endtask

   task automatic idle_bus();
      bus.in_valid = 1'b0;
      bus.in_we_reg = 1'b0;
      bus.in_we_flags = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_op(8'hFF, 7'h7F, 3'd7, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle_bus();
      #1;
      n_checks++;
      if (flags_q !== 7'h09) begin n_fail++; $display("FAIL reset_flags got=%h exp=09", flags_q); end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
      n_checks++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
      n_checks++;
      if (retired_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", retired_count); end
      for (int i = 0; i < REG_COUNT; i++) begin
         rd_addr_a = ADDR_W'(i);
         rd_addr_b = ADDR_W'(REG_COUNT - 1 - i);
         #1;
         n_checks++;
         if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_reg%0d got a=%h b=%h exp=00", i, rd_data_a, rd_data_b);
         end
      end
   endtask

   task automatic test_writeback();
      @(negedge clk);
      drive_op(8'h3C, 7'h00, 3'd2, 1'b1, 1'b1);
      rd_addr_a = 3'd2;
      rd_addr_b = 3'd3;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wb_ready got=%b exp=1", bus.in_ready); end
      @(negedge clk);
      idle_bus();
      #1;
      n_checks++;
      if (pending !== 1'b1) begin n_fail++; $display("FAIL wb_pending got=%b exp=1", pending); end
      n_checks++;
      if (rd_data_a !== 8'h3C) begin n_fail++; $display("FAIL wb_forward got=%h exp=3c", rd_data_a); end
      n_checks++;
      if (rd_data_b !== 8'h00) begin n_fail++; $display("FAIL wb_no_forward got=%h exp=00", rd_data_b); end
      n_checks++;
      if (flags_q !== 7'h09) begin n_fail++; $display("FAIL wb_flags_early got=%h exp=09", flags_q); end
      @(negedge clk);
      #1;
      n_checks++;
      if (pending !== 1'b0 || rd_data_a !== 8'h3C) begin
         n_fail++; $display("FAIL wb_commit got pending=%b reg2=%h exp 0/3c", pending, rd_data_a);
      end
      n_checks++;
      if (flags_q !== 7'h00 || retired_count !== 16'd1) begin
         n_fail++; $display("FAIL wb_flags got flags=%h cnt=%0d exp 00/1", flags_q, retired_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [CNT_W-1:0] start_cnt;
      start_cnt = retired_count;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(8'h10 + 8'(i), 7'h55, ADDR_W'(i), 1'b1, 1'b0);
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.in_ready); end
      end
      @(negedge clk);
      idle_bus();
      @(negedge clk);
      #1;
      n_checks++;
      if (retired_count !== start_cnt + 16'd4) begin
         n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", retired_count, start_cnt + 16'd4);
      end
      n_checks++;
      if (flags_q !== 7'h00) begin n_fail++; $display("FAIL b2b_flags got=%h exp=00", flags_q); end
      for (int i = 0; i < 4; i++) begin
         rd_addr_a = ADDR_W'(i);
         #1;
         n_checks++;
         if (rd_data_a !== 8'h10 + 8'(i)) begin
            n_fail++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, rd_data_a, 8'h10 + 8'(i));
         end
      end
   endtask

   task automatic test_hold();
      logic [CNT_W-1:0] c0;
      c0 = retired_count;
      @(negedge clk);
      drive_op(8'hA5, 7'h45, 3'd4, 1'b1, 1'b1);
      rd_addr_a = 3'd4;
      rd_addr_b = 3'd5;
      @(negedge clk);
      hold = 1'b1;
      drive_op(8'h5A, 7'h00, 3'd5, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         flag_ctrl = (i == 1) ? 2'b01 : 2'b00;
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b0 || pending !== 1'b1) begin
            n_fail++; $display("FAIL hold_ready%0d got ready=%b pending=%b exp 0/1", i, bus.in_ready, pending);
         end
         n_checks++;
         if (rd_data_a !== 8'hA5 || rd_data_b !== 8'h00) begin
            n_fail++; $display("FAIL hold_fwd%0d got a=%h b=%h exp a5/00", i, rd_data_a, rd_data_b);
         end
         n_checks++;
         if (retired_count !== c0 || flags_q[6:5] !== 2'b00 || flags_q[3:0] !== 4'h0) begin
            n_fail++; $display("FAIL hold_frozen%0d got cnt=%0d flags=%h exp %0d/x0", i, retired_count, flags_q, c0);
         end
         @(negedge clk);
      end
      flag_ctrl = 2'b00;
      #1;
      n_checks++;
      if (flags_q !== 7'h10) begin n_fail++; $display("FAIL hold_flagctrl got=%h exp=10", flags_q); end
      hold = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got=%b exp=1", bus.in_ready); end
      @(negedge clk);
      idle_bus();
      #1;
      n_checks++;
      if (retired_count !== c0 + 16'd1 || flags_q !== 7'h55 || pending !== 1'b1) begin
         n_fail++; $display("FAIL hold_commit got cnt=%0d flags=%h pend=%b exp %0d/55/1", retired_count, flags_q, pending, c0 + 16'd1);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (rd_data_a !== 8'hA5 || rd_data_b !== 8'h5A || retired_count !== c0 + 16'd2) begin
         n_fail++; $display("FAIL hold_drain got a=%h b=%h cnt=%0d exp a5/5a/%0d", rd_data_a, rd_data_b, retired_count, c0 + 16'd2);
      end
   endtask

   task automatic test_flag_ctrl();
      @(negedge clk);
      drive_op(8'hEE, 7'h7F, 3'd0, 1'b0, 1'b1);
      rd_addr_a = 3'd0;
      @(negedge clk);
      idle_bus();
      flag_ctrl = 2'b10;
      @(negedge clk);
      flag_ctrl = 2'b11;
      #1;
      n_checks++;
      if (flags_q !== 7'h6F) begin n_fail++; $display("FAIL flagctrl_clear got=%h exp=6f", flags_q); end
      n_checks++;
      if (rd_data_a !== 8'h10) begin n_fail++; $display("FAIL flagctrl_no_regwrite got=%h exp=10", rd_data_a); end
      @(negedge clk);
      flag_ctrl = 2'b01;
      #1;
      n_checks++;
      if (flags_q !== 7'h6F) begin n_fail++; $display("FAIL flagctrl_reserved got=%h exp=6f", flags_q); end
      @(negedge clk);
      flag_ctrl = 2'b00;
      #1;
      n_checks++;
      if (flags_q !== 7'h7F) begin n_fail++; $display("FAIL flagctrl_set got=%h exp=7f", flags_q); end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      drive_op(8'hC3, 7'h00, 3'd5, 1'b1, 1'b1);
      rd_addr_a = 3'd5;
      @(negedge clk);
      idle_bus();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (pending !== 1'b0 || rd_data_a !== 8'h00) begin
         n_fail++; $display("FAIL midrst got pending=%b reg5=%h exp 0/00", pending, rd_data_a);
      end
      n_checks++;
      if (flags_q !== 7'h09 || retired_count !== 16'd0) begin
         n_fail++; $display("FAIL midrst_state got flags=%h cnt=%0d exp 09/0", flags_q, retired_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         hold = ($urandom_range(0, 2) == 0);
         flag_ctrl = 2'($urandom_range(0, 3));
         rd_addr_a = ADDR_W'($urandom_range(0, REG_COUNT - 1));
         rd_addr_b = ADDR_W'($urandom_range(0, REG_COUNT - 1));
         if ($urandom_range(0, 3) != 0)
            drive_op(8'($urandom()), 7'($urandom()), ADDR_W'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            idle_bus();
         #1;
         n_checks++;
         if (bus.in_ready !== exp_ready() || pending !== (sb_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_hs%0d got ready=%b pend=%b exp %b/%b", i, bus.in_ready, pending, exp_ready(), sb_q.size() != 0);
         end
         n_checks++;
         if (flags_q !== m_flags || retired_count !== m_cnt) begin
            n_fail++; $display("FAIL rand_arch%0d got flags=%h cnt=%0d exp %h/%0d", i, flags_q, retired_count, m_flags, m_cnt);
         end
         n_checks++;
         if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b)) begin
            n_fail++; $display("FAIL rand_rd%0d got a=%h b=%h exp %h/%h", i, rd_data_a, rd_data_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b));
         end
      end
      @(negedge clk);
      hold = 1'b0;
      flag_ctrl = 2'b00;
      idle_bus();
   endtask

   task automatic test_counter_wrap();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         drive_op(8'h00, 7'h00, 3'd0, 1'b0, 1'b0);
         @(negedge clk);
      end
      idle_bus();
      @(negedge clk);
      #1;
      n_checks++;
      if (retired_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
         n_fail++; $display("FAIL wrap_max got=%h exp=ffff", retired_count);
      end
      drive_op(8'h00, 7'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      idle_bus();
      @(negedge clk);
      #1;
      n_checks++;
      if (retired_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", retired_count); end
   endtask

   initial begin
      rst_n = 1'b0;
      hold = 1'b0;
      flag_ctrl = 2'b00;
      rd_addr_a = '0;
      rd_addr_b = '0;
      bus.in_result = '0;
      bus.in_flags = '0;
      bus.in_dest = '0;
      idle_bus();
      test_reset();
      test_writeback();
      test_back_to_back();
      test_hold();
      test_flag_ctrl();
      test_reset_mid_op();
      test_random();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
